// File: rtl/link_frame_deframer.sv
// link_frame_deframer
//   Receive-side deframer for the RHS2116 coax link. Consumes the decoded bit
//   stream from the Manchester decoder, hunts for SYNC_WORD, extracts 32-bit
//   payload words (MSB first), optionally checks a CRC-8 (poly 0x07, init 0,
//   over payload only), and reports lock / error status.
//
//   Build option: define FRAME_CRC_EN for 48-bit frames with a CRC byte;
//   leave it undefined for 40-bit frames (crc_err_count tied to 0).
//
// Ports
//   clk_sys        in   system clock
//   rst_n          in   async active-low reset
//   rx_bit         in   decoded bit
//   rx_bit_valid   in   rx_bit qualifier, one bit accepted per cycle
//   data_out       out  last good payload word (held between pulses)
//   data_valid     out  one-cycle pulse, data_out is new
//   locked         out  frame alignment established
//   frame_count    out  emitted frames, wraps
//   crc_err_count  out  CRC failures, saturating
//   sync_err_count out  flywheel sync mismatches, saturating
module link_frame_deframer #(
  parameter logic [7:0] SYNC_WORD   = 8'hD5,
  parameter int         LOCK_FRAMES = 2,
  parameter int         LOSS_FRAMES = 3
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        rx_bit,
  input  logic        rx_bit_valid,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        locked,
  output logic [7:0]  frame_count,
  output logic [7:0]  crc_err_count,
  output logic [7:0]  sync_err_count
);
  typedef enum logic [1:0] {HUNT, PAYLOAD, CRC, SYNC_CHK} state_t;
  state_t state, state_nx;

  logic [7:0]  hunt_sr, fld_sr;   // fld_sr collects the CRC byte and flywheel sync byte
  logic [31:0] pay_sr;
  logic [4:0]  bit_cnt;
  logic        sync_ok;
  logic [3:0]  good_cnt, miss_cnt;

  logic [7:0]  hunt_shift, fld_shift;
  logic [31:0] pay_shift, word;
  logic        last8, last32, lose;
  logic        frame_end, sync_hit, sync_miss;
  logic        crc_ok, crc_bad, frame_good;
  logic [3:0]  good_inc, miss_inc;

  assign hunt_shift = {hunt_sr[6:0], rx_bit};
  assign fld_shift  = {fld_sr[6:0], rx_bit};
  assign pay_shift  = {pay_sr[30:0], rx_bit};
  assign last8      = (bit_cnt == 5'd7);
  assign last32     = (bit_cnt == 5'd31);
  assign good_inc   = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
  assign miss_inc   = miss_cnt + 4'd1;
  assign lose       = (miss_inc >= 4'(LOSS_FRAMES));

`ifdef FRAME_CRC_EN
  logic [7:0] crc_calc, crc_next;
  // Bit-serial CRC-8, MSB-first feed; crc_calc holds the full payload CRC by
  // the time the CRC byte is being received.
  assign crc_next = {crc_calc[6:0], 1'b0} ^ ((crc_calc[7] ^ rx_bit) ? 8'h07 : 8'h00);
  assign crc_ok   = (fld_shift == crc_calc);
  assign word     = pay_sr;
`else
  assign crc_ok   = 1'b1;
  assign word     = pay_shift;   // frame ends on the last payload bit itself
`endif
  assign frame_good = frame_end & sync_ok & crc_ok;
  assign crc_bad    = frame_end & sync_ok & ~crc_ok;

  always_comb begin
    state_nx  = state;
    frame_end = 1'b0;
    sync_hit  = 1'b0;
    sync_miss = 1'b0;
    if (rx_bit_valid) begin
      case (state)
        HUNT:    if (hunt_shift == SYNC_WORD) state_nx = PAYLOAD;
        PAYLOAD: if (last32) begin
`ifdef FRAME_CRC_EN
          state_nx = CRC;
`else
          frame_end = 1'b1;
          state_nx  = SYNC_CHK;
`endif
        end
`ifdef FRAME_CRC_EN
        CRC:     if (last8) begin
          frame_end = 1'b1;
          state_nx  = SYNC_CHK;
        end
`endif
        SYNC_CHK: if (last8) begin
          if (fld_shift == SYNC_WORD) begin
            sync_hit = 1'b1;
            state_nx = PAYLOAD;
          end else begin
            sync_miss = 1'b1;
            state_nx  = lose ? HUNT : PAYLOAD;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state          <= HUNT;
      hunt_sr        <= '0;
      fld_sr         <= '0;
      pay_sr         <= '0;
      bit_cnt        <= '0;
      sync_ok        <= 1'b0;
      good_cnt       <= '0;
      miss_cnt       <= '0;
      locked         <= 1'b0;
      data_out       <= '0;
      data_valid     <= 1'b0;
      frame_count    <= '0;
      sync_err_count <= '0;
    end else begin
      state      <= state_nx;
      data_valid <= frame_good;
      if (rx_bit_valid) begin
        case (state)
          HUNT: begin
            hunt_sr <= hunt_shift;
            bit_cnt <= '0;
            if (state_nx == PAYLOAD) sync_ok <= 1'b1;
          end
          PAYLOAD: begin
            pay_sr  <= pay_shift;
            bit_cnt <= bit_cnt + 5'd1;   // wraps 31->0 for the next field
          end
          default: begin
            fld_sr  <= fld_shift;
            bit_cnt <= last8 ? 5'd0 : bit_cnt + 5'd1;
          end
        endcase
        if (sync_hit) sync_ok <= 1'b1;
        if (sync_miss) begin
          sync_ok  <= 1'b0;
          good_cnt <= '0;
          if (sync_err_count != 8'hFF) sync_err_count <= sync_err_count + 8'd1;
          if (lose) begin
            miss_cnt <= '0;
            locked   <= 1'b0;
            hunt_sr  <= '0;
          end else begin
            miss_cnt <= miss_inc;
          end
        end
        if (frame_good) begin
          data_out    <= word;
          frame_count <= frame_count + 8'd1;
          good_cnt    <= good_inc;
          miss_cnt    <= '0;
          if (good_inc >= 4'(LOCK_FRAMES)) locked <= 1'b1;
        end
        if (crc_bad) good_cnt <= '0;
      end
    end
  end

`ifdef FRAME_CRC_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      crc_calc      <= '0;
      crc_err_count <= '0;
    end else if (rx_bit_valid) begin
      if (state == PAYLOAD)        crc_calc <= crc_next;
      else if (state_nx == PAYLOAD) crc_calc <= '0;   // fresh CRC for each payload
      if (crc_bad && crc_err_count != 8'hFF) crc_err_count <= crc_err_count + 8'd1;
    end
  end
`else
  assign crc_err_count = 8'h00;
`endif

endmodule

// File: tb/tb_link_frame_deframer.sv
module tb_link_frame_deframer;
  localparam logic [7:0] SYNC = 8'hD5;
  localparam int LOCK = 2;
  localparam int LOSS = 3;
`ifdef FRAME_CRC_EN
  localparam int FB = 48;
`else
  localparam int FB = 40;
`endif

  logic        clk_sys = 1'b0, rst_n = 1'b0, rx_bit = 1'b0, rx_bit_valid = 1'b0;
  logic [31:0] data_out;
  logic        data_valid, locked;
  logic [7:0]  frame_count, crc_err_count, sync_err_count;

  int n_checks = 0, n_fail = 0, n_pulse = 0;

  always #5 clk_sys = ~clk_sys;

  link_frame_deframer #(.SYNC_WORD(SYNC), .LOCK_FRAMES(LOCK), .LOSS_FRAMES(LOSS)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .frame_count(frame_count), .crc_err_count(crc_err_count), .sync_err_count(sync_err_count)
  );

  // Reference model: works on whole frames held in a bit queue.
  bit          m_hunt;
  logic [7:0]  m_win;
  bit          m_fr[$];
  bit          m_sync_ok, m_locked, m_pulse;
  int          m_good, m_miss;
  logic [7:0]  m_frames, m_crcerr, m_syncerr;
  logic [31:0] m_data;

  // CRC as the remainder of payload*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc8(input logic [31:0] p);
    logic [39:0] r;
    r = {p, 8'h00};
    for (int i = 39; i >= 8; i--) if (r[i]) r = r ^ (40'h107 << (i - 8));
    return r[7:0];
  endfunction

  task automatic model_reset();
    m_hunt = 1; m_win = 0; m_fr.delete(); m_sync_ok = 0; m_locked = 0; m_pulse = 0;
    m_good = 0; m_miss = 0; m_frames = 0; m_crcerr = 0; m_syncerr = 0; m_data = 0;
  endtask

  task automatic model_step(input bit b);
    logic [7:0]  s, c;
    logic [31:0] p;
    bit          ok;
    m_pulse = 0;
    if (m_hunt) begin
      m_win = {m_win[6:0], b};
      if (m_win == SYNC) begin
        m_hunt = 0; m_sync_ok = 1; m_fr.delete();
        for (int i = 7; i >= 0; i--) m_fr.push_back(SYNC[i]);
      end
      return;
    end
    m_fr.push_back(b);
    if (m_fr.size() == 8) begin
      s = 0;
      for (int i = 0; i < 8; i++) s = {s[6:0], m_fr[i]};
      if (s == SYNC) m_sync_ok = 1;
      else begin
        m_sync_ok = 0; m_good = 0; m_miss++;
        if (m_syncerr != 8'hFF) m_syncerr++;
        if (m_miss >= LOSS) begin
          m_miss = 0; m_locked = 0; m_hunt = 1; m_win = 0; m_fr.delete();
        end
      end
    end else if (m_fr.size() == FB) begin
      p = 0; c = 0;
      for (int i = 8; i < 40; i++) p = {p[30:0], m_fr[i]};
      for (int i = 40; i < FB; i++) c = {c[6:0], m_fr[i]};
      if (m_sync_ok) begin
        ok = 1;
`ifdef FRAME_CRC_EN
        ok = (c == crc8(p));
`endif
        if (ok) begin
          m_data = p; m_pulse = 1; m_frames++; m_miss = 0;
          if (m_good < 15) m_good++;
          if (m_good >= LOCK) m_locked = 1;
        end else begin
          m_good = 0;
          if (m_crcerr != 8'hFF) m_crcerr++;
        end
      end
      m_fr.delete();
    end
  endtask

  // Drives one accepted bit (optionally preceded by idle cycles) and compares
  // every output against the model right after the accepting edge.
  task automatic send_bit(input bit b, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk_sys); rx_bit_valid = 0; rx_bit = 1'($urandom_range(0, 1));
      @(posedge clk_sys); #1;
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid: got %b want 0", data_valid); end
    end
    @(negedge clk_sys); rx_bit = b; rx_bit_valid = 1;
    @(posedge clk_sys); model_step(b); #1;
    rx_bit_valid = 0;
    if (data_valid === 1'b1) n_pulse++;
    n_checks += 6;
    if (data_valid !== m_pulse)     begin n_fail++; $display("FAIL bit_valid: got %b want %b", data_valid, m_pulse); end
    if (data_out !== m_data)        begin n_fail++; $display("FAIL bit_data: got %h want %h", data_out, m_data); end
    if (locked !== m_locked)        begin n_fail++; $display("FAIL bit_locked: got %b want %b", locked, m_locked); end
    if (frame_count !== m_frames)   begin n_fail++; $display("FAIL bit_frames: got %0d want %0d", frame_count, m_frames); end
    if (crc_err_count !== m_crcerr) begin n_fail++; $display("FAIL bit_crcerr: got %0d want %0d", crc_err_count, m_crcerr); end
    if (sync_err_count !== m_syncerr) begin n_fail++; $display("FAIL bit_syncerr: got %0d want %0d", sync_err_count, m_syncerr); end
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [31:0] p, input logic [7:0] flip,
                            input bit gapped, output bit pulsed);
    logic [47:0] f;
    int gaps;
    f = {s, p, crc8(p) ^ flip};
    for (int i = 47; i >= 48 - FB; i--) begin
      gaps = 0;
      if (gapped) while (gaps < 20 && $urandom_range(0, 2) != 0) gaps++;
      send_bit(f[i], gaps);
    end
    pulsed = (data_valid === 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk_sys); rst_n = 0; model_reset();
    @(negedge clk_sys); rst_n = 1;
  endtask

  task automatic test_reset();
    logic [7:0] w;
    int p0;
    bit b;
    do_reset();
    for (int i = 0; i < 30; i++) send_bit(1'($urandom_range(0, 1)), 0);
    @(negedge clk_sys); rst_n = 0; model_reset(); #2;
    n_checks += 6;
    if (data_out !== 32'h0)       begin n_fail++; $display("FAIL rst_data: got %h want 0", data_out); end
    if (data_valid !== 1'b0)      begin n_fail++; $display("FAIL rst_valid: got %b want 0", data_valid); end
    if (locked !== 1'b0)          begin n_fail++; $display("FAIL rst_locked: got %b want 0", locked); end
    if (frame_count !== 8'h0)     begin n_fail++; $display("FAIL rst_frames: got %0d want 0", frame_count); end
    if (crc_err_count !== 8'h0)   begin n_fail++; $display("FAIL rst_crcerr: got %0d want 0", crc_err_count); end
    if (sync_err_count !== 8'h0)  begin n_fail++; $display("FAIL rst_syncerr: got %0d want 0", sync_err_count); end
    @(negedge clk_sys); rst_n = 1;
    w = 0; p0 = n_pulse;
    for (int i = 0; i < 200; i++) begin
      b = 1'($urandom_range(0, 1));
      if ({w[6:0], b} == SYNC) b = ~b;
      w = {w[6:0], b};
      send_bit(b, 0);
    end
    n_checks += 2;
    if (n_pulse != p0)       begin n_fail++; $display("FAIL nosync_emit: got %0d pulses want 0", n_pulse - p0); end
    if (locked !== 1'b0)     begin n_fail++; $display("FAIL nosync_locked: got %b want 0", locked); end
  endtask

  task automatic test_clean();
    bit pl;
    do_reset();
    send_frame(SYNC, 32'h12345678, 8'h00, 0, pl);
    n_checks += 4;
    if (pl !== 1'b1)               begin n_fail++; $display("FAIL clean1_pulse: got %b want 1", pl); end
    if (data_out !== 32'h12345678) begin n_fail++; $display("FAIL clean1_data: got %h want 12345678", data_out); end
    if (frame_count !== 8'd1)      begin n_fail++; $display("FAIL clean1_frames: got %0d want 1", frame_count); end
    if (locked !== 1'b0)           begin n_fail++; $display("FAIL clean1_locked: got %b want 0", locked); end
    send_frame(SYNC, 32'hDEADBEEF, 8'h00, 0, pl);
    n_checks += 4;
    if (pl !== 1'b1)               begin n_fail++; $display("FAIL clean2_pulse: got %b want 1", pl); end
    if (data_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL clean2_data: got %h want deadbeef", data_out); end
    if (frame_count !== 8'd2)      begin n_fail++; $display("FAIL clean2_frames: got %0d want 2", frame_count); end
    if (locked !== 1'b1)           begin n_fail++; $display("FAIL clean2_locked: got %b want 1", locked); end
  endtask

`ifdef FRAME_CRC_EN
  task automatic test_crc_err();
    bit pl;
    do_reset();
    send_frame(SYNC, 32'h11111111, 8'h00, 0, pl);
    send_frame(SYNC, 32'h22222222, 8'h00, 0, pl);
    send_frame(SYNC, 32'h0BADF00D, 8'h01, 0, pl);
    n_checks += 5;
    if (pl !== 1'b0)              begin n_fail++; $display("FAIL crc_pulse: got %b want 0", pl); end
    if (crc_err_count !== 8'd1)   begin n_fail++; $display("FAIL crc_count: got %0d want 1", crc_err_count); end
    if (locked !== 1'b1)          begin n_fail++; $display("FAIL crc_locked: got %b want 1", locked); end
    if (frame_count !== 8'd2)     begin n_fail++; $display("FAIL crc_frames: got %0d want 2", frame_count); end
    if (data_out !== 32'h22222222) begin n_fail++; $display("FAIL crc_hold: got %h want 22222222", data_out); end
    send_frame(SYNC, 32'h55AA33CC, 8'h00, 0, pl);
    n_checks += 3;
    if (pl !== 1'b1)               begin n_fail++; $display("FAIL crc_next_pulse: got %b want 1", pl); end
    if (data_out !== 32'h55AA33CC) begin n_fail++; $display("FAIL crc_next_data: got %h want 55aa33cc", data_out); end
    if (frame_count !== 8'd3)      begin n_fail++; $display("FAIL crc_next_frames: got %0d want 3", frame_count); end
  endtask
`endif

  task automatic test_sync_loss();
    bit pl;
    do_reset();
    send_frame(SYNC, 32'hA1B2C3D4, 8'h00, 0, pl);
    send_frame(SYNC, 32'h01020304, 8'h00, 0, pl);
    for (int k = 1; k <= 3; k++) begin
      send_frame(8'h00, 32'h0, 8'h00, 0, pl);
      n_checks += 3;
      if (pl !== 1'b0)                      begin n_fail++; $display("FAIL loss_pulse%0d: got %b want 0", k, pl); end
      if (sync_err_count !== 8'(k))         begin n_fail++; $display("FAIL loss_count%0d: got %0d want %0d", k, sync_err_count, k); end
      if (locked !== (k < 3 ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL loss_locked%0d: got %b want %b", k, locked, k < 3); end
    end
    n_checks += 1;
    if (frame_count !== 8'd2) begin n_fail++; $display("FAIL loss_frames: got %0d want 2", frame_count); end
    send_frame(SYNC, 32'hCAFEF00D, 8'h00, 0, pl);
    n_checks += 3;
    if (pl !== 1'b1)               begin n_fail++; $display("FAIL reacq_pulse: got %b want 1", pl); end
    if (data_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL reacq_data: got %h want cafef00d", data_out); end
    if (frame_count !== 8'd3)      begin n_fail++; $display("FAIL reacq_frames: got %0d want 3", frame_count); end
  endtask

  task automatic test_gapped();
    bit pl;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      send_frame(SYNC, 32'hA5A50F0F, 8'h00, run == 1, pl);
      send_frame(SYNC, 32'hA5A50F0F, 8'h00, run == 1, pl);
      n_checks += 4;
      if (pl !== 1'b1)               begin n_fail++; $display("FAIL gap%0d_pulse: got %b want 1", run, pl); end
      if (data_out !== 32'hA5A50F0F) begin n_fail++; $display("FAIL gap%0d_data: got %h want a5a50f0f", run, data_out); end
      if (frame_count !== 8'd2)      begin n_fail++; $display("FAIL gap%0d_frames: got %0d want 2", run, frame_count); end
      if (locked !== 1'b1)           begin n_fail++; $display("FAIL gap%0d_locked: got %b want 1", run, locked); end
    end
  endtask

  task automatic test_reset_mid();
    bit pl;
    int p0;
    logic [31:0] p;
    do_reset();
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], 0);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 0);
    @(negedge clk_sys); rst_n = 0; model_reset(); #2;
    n_checks += 1;
    if (frame_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_frames: got %0d want 0", frame_count); end
    @(negedge clk_sys); rst_n = 1;
    p0 = n_pulse; p = $urandom;
    send_frame(SYNC, p, 8'h00, 0, pl);
    n_checks += 3;
    if (n_pulse - p0 != 1)    begin n_fail++; $display("FAIL mid_emits: got %0d want 1", n_pulse - p0); end
    if (frame_count !== 8'd1) begin n_fail++; $display("FAIL mid_frames: got %0d want 1", frame_count); end
    if (data_out !== p)       begin n_fail++; $display("FAIL mid_data: got %h want %h", data_out, p); end
  endtask

  task automatic test_random();
    bit pl;
    logic [7:0] s, fl;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      s  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : SYNC;
      fl = ($urandom_range(0, 4) == 0) ? (8'h1 << $urandom_range(0, 7)) : 8'h00;
      send_frame(s, $urandom, fl, $urandom_range(0, 3) == 0, pl);
      n_checks += 1;
      if (pl !== m_pulse) begin n_fail++; $display("FAIL rand_frame%0d: got %b want %b", k, pl, m_pulse); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12 rst_n = 1;
    test_reset();
    test_clean();
`ifdef FRAME_CRC_EN
    test_crc_err();
`endif
    test_sync_loss();
    test_gapped();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
